hwacc_mr_tag_sched: RTL and testbench
=====================================

HWACC_MR_TAG_SCHED -- requirements
Module: hwacc_mr_tag_sched

Interface
REQ-001 SHALL have parameter REQ_TAG_NUM, default 32, meaning the number of outstanding MR translation tags.
REQ-002 SHALL have parameter REQ_TAG_NUM_LOG, default 5, meaning the tag width.
REQ-003 SHALL have parameter PAGE_SIZE, default 4096, meaning the MTT page size in bytes.
REQ-004 SHALL have parameter COUNT_MAX_LOG, default 2, meaning the width of the page-count field.
REQ-005 Port: clk  in  1  single clock; all logic on posedge.
REQ-006 Port: rst_n  in  1  asynchronous, active-low reset.
REQ-007 Port: mr_req_valid/mr_req_ready  in/out  1/1  valid-ready handshake for MR translation requests.
REQ-008 Port: mr_req_data  in  96  {length[31:0], vaddr[63:0]}.
REQ-009 Port: mtt_get_req_valid/mtt_get_req_ready  out/in  1/1  valid-ready handshake for MTT get requests.
REQ-010 Port: mtt_get_req_head  out  COUNT_MAX_LOG*2+REQ_TAG_NUM_LOG+64  {count_total, 2'b00, tag, mtt_index[63:0]}.
REQ-011 Port: page_offset_buffer_wen/addr/din  out  1/REQ_TAG_NUM_LOG/44  writes {length[31:0], offset[11:0]} at the tag address.
REQ-012 Port: tag_free_valid/tag_free_tag  in  1/REQ_TAG_NUM_LOG  one-cycle tag release from the response-forward stage.
REQ-013 Port: req_err  out  1  one-cycle pulse when an oversize request is dropped.
REQ-014 Port: tags_in_flight  out  REQ_TAG_NUM_LOG+1  count of allocated tags.

Function
REQ-015 SHALL keep a REQ_TAG_NUM-bit free bitmap, reset to all ones.
REQ-016 SHALL run an FSM with states IDLE, WR_OFFSET and ISSUE.
REQ-017 mr_req_ready SHALL be 1 only in IDLE with at least one free tag.
REQ-018 On an accepted request, the block SHALL latch vaddr, length and the lowest-index free tag, and clear that tag's bitmap bit.
REQ-019 On an accepted request, the block SHALL compute offset=vaddr[11:0] and mtt_index=vaddr[63:12] zero-extended.
REQ-020 On an accepted request, count_total SHALL be 2 if offset+length>PAGE_SIZE (33-bit sum), else 1; length 0 SHALL give 1.
REQ-021 If length>PAGE_SIZE, the request SHALL be accepted and dropped: req_err pulses for 1 cycle, no tag is allocated, and the FSM stays in IDLE.
REQ-022 From IDLE, a valid accepted request SHALL move the FSM to WR_OFFSET.
REQ-023 In WR_OFFSET, page_offset_buffer_wen SHALL be 1 for exactly one cycle with addr=tag and din={length, offset}; the FSM then moves to ISSUE.
REQ-024 In ISSUE, mtt_get_req_valid SHALL be 1 with a stable head until mtt_get_req_ready; the FSM then moves to IDLE.
REQ-025 Latency from mr_req accept to mtt_get_req_valid SHALL be 2 cycles.
REQ-026 tag_free_valid SHALL set the bitmap bit next cycle in any state.
REQ-027 A free in the same cycle as an allocation SHALL apply both; the freed tag SHALL NOT be selectable until the following cycle.
REQ-028 When all tags are allocated, mr_req_ready SHALL be 0; the first cycle after a free, ready SHALL be 1.
REQ-029 tags_in_flight SHALL increment on allocation and decrement on a valid free; both in one cycle SHALL leave it unchanged.
REQ-030 page_offset_buffer_din, addr and mtt_get_req_head SHALL be 0 outside their active states.

Reset
REQ-031 rst_n low SHALL asynchronously force IDLE, bitmap all ones, tags_in_flight 0, all valid/wen/err outputs 0, and latched fields 0.
REQ-032 Reset mid-ISSUE SHALL abandon the request with no retry; the tag is returned.

Configuration
REQ-033 With HWACC_MR_TAG_CHECK_EN defined, an extra output tag_dfree_err SHALL pulse 1 cycle when tag_free_tag is already free; the bitmap and counter SHALL be unchanged.
REQ-034 Without HWACC_MR_TAG_CHECK_EN, a double free SHALL be silently ignored, with bitmap and counter unchanged and no extra port.

Structure
REQ-035 MR_REQ_DATA_WIDTH, the head field offsets and the FSM state encodings SHALL live in the shared MR-management package/header.
REQ-036 Free-tag selection SHALL be a sub-module hwacc_mr_tag_prienc: bitmap in, lowest-index tag plus any_free out, purely combinational.

Verification
REQ-037 vaddr=0x1000_0100, length=0x200 -> offset buffer write {0x200,0x100} at tag 0; head count=1, index=0x10000, tag=0.
REQ-038 vaddr=0x2FF0, length=0x20 -> count=2, index=0x2, tag=next free (1).
REQ-039 length=0x1001 -> req_err 1 cycle, no wen, tags_in_flight unchanged.
REQ-040 32 requests with no frees -> ready=0 and tags_in_flight=32; free tag 7 -> next request gets tag 7.
REQ-041 mtt_get_req_ready held low 5 cycles -> head stable, mr_req_ready=0; a free during the hold is still counted.
REQ-042 Free tag 3 while it is already free (with CHECK_EN) -> tag_dfree_err pulses, counter unchanged.

Source files
------------

// File: rtl/hwacc_mr_tag_sched_pkg.sv
// Shared MR-management definitions: request layout, MTT get head field offsets, scheduler states.
package hwacc_mr_tag_sched_pkg;

    localparam int MR_REQ_DATA_WIDTH = 96;
    localparam int MR_VADDR_W        = 64;
    localparam int MR_LEN_W          = 32;
    localparam int MR_LEN_LSB        = 64;
    localparam int PAGE_OFF_W        = 12;
    localparam int OFFSET_BUF_W      = MR_LEN_W + PAGE_OFF_W;
    localparam int SPAN_W            = MR_LEN_W + 1;

    localparam int HEAD_IDX_LSB      = 0;
    localparam int HEAD_IDX_W        = 64;
    localparam int HEAD_TAG_LSB      = 64;

    // count_total sits above the tag and a cnt_w-wide zero pad
    function automatic int head_cnt_lsb(input int tag_w, input int cnt_w);
        return HEAD_TAG_LSB + tag_w + cnt_w;
    endfunction

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_WR_OFFSET = 2'd1,
        ST_ISSUE     = 2'd2
    } mr_state_e;

endpackage

// File: rtl/hwacc_mr_tag_prienc.sv
// Lowest-index free tag selector over the free bitmap; purely combinational.
module hwacc_mr_tag_prienc #(
    parameter int N   = 32,
    parameter int LOG = 5
) (
    input  logic [N-1:0]   i_map,
    output logic [LOG-1:0] o_tag,
    output logic           o_any_free
);

    always_comb begin
        o_tag = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (i_map[i]) o_tag = LOG'(i);
        end
    end

    assign o_any_free = |i_map;

endmodule

// File: rtl/hwacc_mr_tag_sched.sv
// MR translation tag scheduler: allocates a tag per request, writes the page offset, issues MTT get.
// Optional double-free detection output enabled by defining HWACC_MR_TAG_CHECK_EN.
module hwacc_mr_tag_sched
    import hwacc_mr_tag_sched_pkg::*;
#(
    parameter int REQ_TAG_NUM     = 32,
    parameter int REQ_TAG_NUM_LOG = 5,
    parameter int PAGE_SIZE       = 4096,
    parameter int COUNT_MAX_LOG   = 2
) (
    input  logic                                          clk,
    input  logic                                          rst_n,
    input  logic                                          mr_req_valid,
    output logic                                          mr_req_ready,
    input  logic [MR_REQ_DATA_WIDTH-1:0]                  mr_req_data,
    output logic                                          mtt_get_req_valid,
    input  logic                                          mtt_get_req_ready,
    output logic [COUNT_MAX_LOG*2+REQ_TAG_NUM_LOG+63:0]   mtt_get_req_head,
    output logic                                          page_offset_buffer_wen,
    output logic [REQ_TAG_NUM_LOG-1:0]                    page_offset_buffer_addr,
    output logic [OFFSET_BUF_W-1:0]                       page_offset_buffer_din,
    input  logic                                          tag_free_valid,
    input  logic [REQ_TAG_NUM_LOG-1:0]                    tag_free_tag,
    output logic                                          req_err,
`ifdef HWACC_MR_TAG_CHECK_EN
    output logic                                          tag_dfree_err,
`endif
    output logic [REQ_TAG_NUM_LOG:0]                      tags_in_flight
);

    localparam int                   HEAD_W  = COUNT_MAX_LOG*2 + REQ_TAG_NUM_LOG + HEAD_IDX_W;
    localparam int                   CNT_LSB = head_cnt_lsb(REQ_TAG_NUM_LOG, COUNT_MAX_LOG);
    localparam logic [REQ_TAG_NUM_LOG:0] INF_ONE = 1;

    mr_state_e                  r_state, w_state_nxt;
    logic [REQ_TAG_NUM-1:0]     r_free_map, w_free_map_nxt;
    logic [REQ_TAG_NUM_LOG:0]   r_inflight;
    logic [REQ_TAG_NUM_LOG-1:0] r_tag, w_pe_tag;
    logic [MR_LEN_W-1:0]        r_len;
    logic [PAGE_OFF_W-1:0]      r_off;
    logic [HEAD_IDX_W-1:0]      r_idx;
    logic [COUNT_MAX_LOG-1:0]   r_cnt;
    logic                       r_err;
    logic                       w_any_free;

    logic [MR_LEN_W-1:0]        w_len;
    logic [MR_VADDR_W-1:0]      w_vaddr;
    logic [PAGE_OFF_W-1:0]      w_off;
    logic [HEAD_IDX_W-1:0]      w_idx;
    logic [SPAN_W-1:0]          w_span;
    logic                       w_two_pages, w_oversize;
    logic                       w_accept, w_alloc, w_free_ok;
    logic [HEAD_W-1:0]          w_head;

    hwacc_mr_tag_prienc #(
        .N   (REQ_TAG_NUM),
        .LOG (REQ_TAG_NUM_LOG)
    ) u_prienc (
        .i_map      (r_free_map),
        .o_tag      (w_pe_tag),
        .o_any_free (w_any_free)
    );

    assign w_len       = mr_req_data[MR_LEN_LSB +: MR_LEN_W];
    assign w_vaddr     = mr_req_data[0 +: MR_VADDR_W];
    assign w_off       = w_vaddr[PAGE_OFF_W-1:0];
    assign w_idx       = HEAD_IDX_W'(w_vaddr[MR_VADDR_W-1:PAGE_OFF_W]);
    assign w_span      = {1'b0, w_len} + SPAN_W'(w_off);
    assign w_two_pages = w_span > SPAN_W'(PAGE_SIZE);
    assign w_oversize  = {1'b0, w_len} > SPAN_W'(PAGE_SIZE);

    assign w_accept  = mr_req_valid & mr_req_ready;
    assign w_alloc   = w_accept & ~w_oversize;
    // Freeing a tag that is already free is a no-op on both bitmap and counter
    assign w_free_ok = tag_free_valid & ~r_free_map[tag_free_tag];

    always_comb begin
        w_free_map_nxt = r_free_map;
        if (w_alloc)   w_free_map_nxt[w_pe_tag]     = 1'b0;
        if (w_free_ok) w_free_map_nxt[tag_free_tag] = 1'b1;
    end

    always_comb begin
        w_state_nxt            = r_state;
        mr_req_ready           = 1'b0;
        page_offset_buffer_wen = 1'b0;
        mtt_get_req_valid      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                mr_req_ready = w_any_free;
                if (w_alloc) w_state_nxt = ST_WR_OFFSET;
            end
            ST_WR_OFFSET: begin
                page_offset_buffer_wen = 1'b1;
                w_state_nxt            = ST_ISSUE;
            end
            ST_ISSUE: begin
                mtt_get_req_valid = 1'b1;
                if (mtt_get_req_ready) w_state_nxt = ST_IDLE;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_IDLE;
            r_free_map <= '1;
            r_inflight <= '0;
            r_tag      <= '0;
            r_len      <= '0;
            r_off      <= '0;
            r_idx      <= '0;
            r_cnt      <= '0;
            r_err      <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_free_map <= w_free_map_nxt;
            r_err      <= w_accept & w_oversize;
            if (w_alloc && !w_free_ok)      r_inflight <= r_inflight + INF_ONE;
            else if (!w_alloc && w_free_ok) r_inflight <= r_inflight - INF_ONE;
            if (w_alloc) begin
                r_tag <= w_pe_tag;
                r_len <= w_len;
                r_off <= w_off;
                r_idx <= w_idx;
                r_cnt <= w_two_pages ? COUNT_MAX_LOG'(2) : COUNT_MAX_LOG'(1);
            end
        end
    end

`ifdef HWACC_MR_TAG_CHECK_EN
    logic r_dfree_err;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_dfree_err <= 1'b0;
        else        r_dfree_err <= tag_free_valid & r_free_map[tag_free_tag];
    end

    assign tag_dfree_err = r_dfree_err;
`endif

    always_comb begin
        w_head = '0;
        if (r_state == ST_ISSUE) begin
            w_head[HEAD_IDX_LSB +: HEAD_IDX_W]     = r_idx;
            w_head[HEAD_TAG_LSB +: REQ_TAG_NUM_LOG] = r_tag;
            w_head[CNT_LSB +: COUNT_MAX_LOG]        = r_cnt;
        end
    end

    assign mtt_get_req_head        = w_head;
    assign page_offset_buffer_addr = (r_state == ST_WR_OFFSET) ? r_tag : '0;
    assign page_offset_buffer_din  = (r_state == ST_WR_OFFSET) ? {r_len, r_off} : '0;
    assign req_err                 = r_err;
    assign tags_in_flight          = r_inflight;

endmodule

// File: tb/tb_hwacc_mr_tag_sched.sv
// Directed bench for hwacc_mr_tag_sched; define HWACC_MR_TAG_CHECK_EN to cover double-free reporting.
module tb_hwacc_mr_tag_sched;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        mr_req_valid = 1'b0;
    logic        mr_req_ready;
    logic [95:0] mr_req_data = '0;
    logic        mtt_get_req_valid;
    logic        mtt_get_req_ready = 1'b0;
    logic [72:0] mtt_get_req_head;
    logic        page_offset_buffer_wen;
    logic [4:0]  page_offset_buffer_addr;
    logic [43:0] page_offset_buffer_din;
    logic        tag_free_valid = 1'b0;
    logic [4:0]  tag_free_tag = '0;
    logic        req_err;
    logic [5:0]  tags_in_flight;
`ifdef HWACC_MR_TAG_CHECK_EN
    logic        tag_dfree_err;
`endif

    int n_cmp = 0;
    int n_err = 0;

    hwacc_mr_tag_sched dut (
        .clk                     (clk),
        .rst_n                   (rst_n),
        .mr_req_valid            (mr_req_valid),
        .mr_req_ready            (mr_req_ready),
        .mr_req_data             (mr_req_data),
        .mtt_get_req_valid       (mtt_get_req_valid),
        .mtt_get_req_ready       (mtt_get_req_ready),
        .mtt_get_req_head        (mtt_get_req_head),
        .page_offset_buffer_wen  (page_offset_buffer_wen),
        .page_offset_buffer_addr (page_offset_buffer_addr),
        .page_offset_buffer_din  (page_offset_buffer_din),
        .tag_free_valid          (tag_free_valid),
        .tag_free_tag            (tag_free_tag),
        .req_err                 (req_err),
`ifdef HWACC_MR_TAG_CHECK_EN
        .tag_dfree_err           (tag_dfree_err),
`endif
        .tags_in_flight          (tags_in_flight)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h", tag, got, exp);
        end
    endtask

    function automatic logic [72:0] hd(input logic [1:0] c, input logic [4:0] t, input logic [63:0] idx);
        return {c, 2'b00, t, idx};
    endfunction

    task automatic step();
        @(posedge clk);
        #3;
    endtask

    // Present one request for a single cycle; returns sampled in WR_OFFSET (or IDLE if dropped)
    task automatic send(input logic [63:0] va, input logic [31:0] len);
        mr_req_valid = 1'b1;
        mr_req_data  = {len, va};
        #1;
        step();
        mr_req_valid = 1'b0;
        mr_req_data  = '0;
        #1;
    endtask

    // From WR_OFFSET: move to ISSUE, accept the head, back to IDLE
    task automatic retire();
        step();
        mtt_get_req_ready = 1'b1;
        step();
        mtt_get_req_ready = 1'b0;
        #1;
    endtask

    task automatic free_tag(input logic [4:0] t);
        tag_free_valid = 1'b1;
        tag_free_tag   = t;
        step();
        tag_free_valid = 1'b0;
        tag_free_tag   = '0;
        #1;
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #3;
        chk("rst_inflight", tags_in_flight, 0);
        chk("rst_mtt_valid", mtt_get_req_valid, 0);
        chk("rst_wen", page_offset_buffer_wen, 0);
        chk("rst_err", req_err, 0);
        chk("rst_head", mtt_get_req_head, 0);
        chk("rst_din", page_offset_buffer_din, 0);
        chk("rst_addr", page_offset_buffer_addr, 0);
        rst_n = 1'b1;
        step();
        chk("idle_ready", mr_req_ready, 1);

        // single-page request, tag 0
        send(64'h1000_0100, 32'h200);
        chk("r1_wen", page_offset_buffer_wen, 1);
        chk("r1_addr", page_offset_buffer_addr, 0);
        chk("r1_din", page_offset_buffer_din, {32'h200, 12'h100});
        chk("r1_valid_early", mtt_get_req_valid, 0);
        chk("r1_ready_busy", mr_req_ready, 0);
        chk("r1_inflight", tags_in_flight, 1);
        step();
        chk("r1_valid", mtt_get_req_valid, 1);
        chk("r1_head", mtt_get_req_head, hd(2'd1, 5'd0, 64'h10000));
        chk("r1_wen_off", page_offset_buffer_wen, 0);
        chk("r1_din_off", page_offset_buffer_din, 0);
        mtt_get_req_ready = 1'b1;
        step();
        mtt_get_req_ready = 1'b0;
        #1;
        chk("r1_valid_done", mtt_get_req_valid, 0);
        chk("r1_head_off", mtt_get_req_head, 0);

        // page-crossing request, tag 1
        send(64'h2FF0, 32'h20);
        chk("r2_addr", page_offset_buffer_addr, 1);
        chk("r2_din", page_offset_buffer_din, {32'h20, 12'hFF0});
        step();
        chk("r2_head", mtt_get_req_head, hd(2'd2, 5'd1, 64'h2));
        mtt_get_req_ready = 1'b1;
        step();
        mtt_get_req_ready = 1'b0;
        #1;

        // oversize request is dropped
        send(64'h0, 32'h1001);
        chk("ovr_err", req_err, 1);
        chk("ovr_wen", page_offset_buffer_wen, 0);
        chk("ovr_inflight", tags_in_flight, 2);
        chk("ovr_ready", mr_req_ready, 1);
        step();
        chk("ovr_err_pulse", req_err, 0);

        // exactly one full page at offset 0 stays single-page
        send(64'h5000, 32'h1000);
        chk("pg_addr", page_offset_buffer_addr, 2);
        chk("pg_din", page_offset_buffer_din, {32'h1000, 12'h000});
        step();
        chk("pg_head", mtt_get_req_head, hd(2'd1, 5'd2, 64'h5));
        mtt_get_req_ready = 1'b1;
        step();
        mtt_get_req_ready = 1'b0;
        #1;

        // exhaust the remaining tags
        for (int i = 3; i < 32; i++) begin
            send(64'(i) << 12, 32'h10);
            retire();
        end
        chk("full_inflight", tags_in_flight, 32);
        chk("full_ready", mr_req_ready, 0);
        mr_req_valid = 1'b1;
        mr_req_data  = {32'h10, 64'h9000};
        step();
        mr_req_valid = 1'b0;
        mr_req_data  = '0;
        #1;
        chk("full_no_wen", page_offset_buffer_wen, 0);
        chk("full_inflight2", tags_in_flight, 32);

        // free tag 7 and reuse it
        tag_free_valid = 1'b1;
        tag_free_tag   = 5'd7;
        #1;
        chk("free7_same_cycle", mr_req_ready, 0);
        step();
        tag_free_valid = 1'b0;
        #1;
        chk("free7_ready", mr_req_ready, 1);
        chk("free7_inflight", tags_in_flight, 31);
        send(64'h7000, 32'h10);
        chk("reuse7_addr", page_offset_buffer_addr, 7);
        chk("reuse7_inflight", tags_in_flight, 32);
        step();

        // hold the MTT head with a free of tag 12 in the middle
        for (int k = 0; k < 5; k++) begin
            chk("hold_valid", mtt_get_req_valid, 1);
            chk("hold_head", mtt_get_req_head, hd(2'd1, 5'd7, 64'h7));
            chk("hold_ready", mr_req_ready, 0);
            if (k == 2) begin
                tag_free_valid = 1'b1;
                tag_free_tag   = 5'd12;
            end
            step();
            tag_free_valid = 1'b0;
            #1;
        end
        chk("hold_inflight", tags_in_flight, 31);
        chk("hold_still_valid", mtt_get_req_valid, 1);
        mtt_get_req_ready = 1'b1;
        step();
        mtt_get_req_ready = 1'b0;
        #1;
        chk("hold_after_ready", mr_req_ready, 1);
        send(64'h8000, 32'h10);
        chk("reuse12_addr", page_offset_buffer_addr, 12);
        retire();

        // free tag 3 twice: the second free has no effect
        free_tag(5'd3);
        chk("free3_inflight", tags_in_flight, 31);
        free_tag(5'd3);
        chk("dfree_inflight", tags_in_flight, 31);
`ifdef HWACC_MR_TAG_CHECK_EN
        chk("dfree_err", tag_dfree_err, 1);
        step();
        chk("dfree_err_pulse", tag_dfree_err, 0);
`endif

        // allocation and free of another tag in the same cycle
        tag_free_valid = 1'b1;
        tag_free_tag   = 5'd20;
        send(64'h9000, 32'h10);
        tag_free_valid = 1'b0;
        #1;
        chk("same_addr", page_offset_buffer_addr, 3);
        chk("same_inflight", tags_in_flight, 31);
        retire();
        send(64'hA000, 32'h10);
        chk("next20_addr", page_offset_buffer_addr, 20);
        chk("next20_inflight", tags_in_flight, 32);
        retire();

        // reset while ISSUE is waiting
        free_tag(5'd5);
        send(64'hB000, 32'h10);
        chk("rst_req_addr", page_offset_buffer_addr, 5);
        step();
        chk("rst_req_valid", mtt_get_req_valid, 1);
        rst_n = 1'b0;
        #1;
        chk("amid_valid", mtt_get_req_valid, 0);
        chk("amid_inflight", tags_in_flight, 0);
        chk("amid_head", mtt_get_req_head, 0);
        step();
        rst_n = 1'b1;
        step();
        send(64'h1000, 32'h0);
        chk("post_addr", page_offset_buffer_addr, 0);
        chk("post_din", page_offset_buffer_din, 0);
        chk("post_inflight", tags_in_flight, 1);
        step();
        chk("post_head", mtt_get_req_head, hd(2'd1, 5'd0, 64'h1));
        mtt_get_req_ready = 1'b1;
        step();
        mtt_get_req_ready = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
